// File: rtl/chromosome_evaluation_sequencer.sv
// Generation-level controller for chromosomeProcessingStateMachine.
// For each chromosome in RAM it assembles the 992-bit description, runs the
// processor start/done/feedback handshake, reduces the eight error sums to a
// saturated fitness word, writes it out and tracks the generation's best.
module chromosome_evaluation_sequencer #(
    parameter int POP_SIZE        = 16,
    parameter int WORDS_PER_CHROM = 31,
    parameter int ADDR_WIDTH      = 13
) (
    input  logic                            iClock,
    input  logic                            iReset,
    input  logic                            iStartGeneration,
    output logic                            oBusy,
    output logic                            oGenerationDone,
    output logic [ADDR_WIDTH-1:0]           oChromMemAddr,
    input  logic [31:0]                     iChromMemData,
    output logic [WORDS_PER_CHROM*32-1:0]   oConcatedChromDescription,
    output logic                            oStartProcessing,
    input  logic                            iReadyToProcess,
    input  logic                            iDoneProcessing,
    output logic                            oDoneProcessingFeedback,
    input  logic [255:0]                    iErrorSums,
    output logic                            oFitnessWrite,
    output logic [7:0]                      oFitnessAddr,
    output logic [31:0]                     oFitnessData,
    output logic [7:0]                      oBestIndex,
    output logic [31:0]                     oBestFitness,
    output logic                            oPerfectFound
);

    // Controller states
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] LOAD       = 4'd1;
    localparam logic [3:0] WAIT_READY = 4'd2;
    localparam logic [3:0] START      = 4'd3;
    localparam logic [3:0] WAIT_DONE  = 4'd4;
    localparam logic [3:0] SCORE      = 4'd5;
    localparam logic [3:0] ACK        = 4'd6;
    localparam logic [3:0] NEXT       = 4'd7;
    localparam logic [3:0] DONE       = 4'd8;

    // The word counter must reach WORDS_PER_CHROM (the final capture cycle)
    localparam int                     WCNT_W       = $clog2(WORDS_PER_CHROM + 1);
    localparam logic [WCNT_W-1:0]      LAST_WORD    = WCNT_W'(WORDS_PER_CHROM - 1);
    localparam logic [WCNT_W-1:0]      LOAD_END     = WCNT_W'(WORDS_PER_CHROM);
    localparam logic [7:0]             LAST_INDEX   = 8'(POP_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0]  CHROM_STRIDE = ADDR_WIDTH'(WORDS_PER_CHROM);

    logic [3:0]            state;
    logic [WCNT_W-1:0]     wordCount;
    logic [WCNT_W-1:0]     captureSlot;
    logic [ADDR_WIDTH-1:0] chromBase;
    logic [7:0]            chromIndex;

    logic [31:0]           errLane [8];
    logic [34:0]           sumWide;
    logic [31:0]           fitness;

    assign oBusy = (state != IDLE);

    // In LOAD cycle c the RAM returns the word addressed in cycle c-1
    assign captureSlot = wordCount - WCNT_W'(1);

    // Split the error-sum bus into its eight 32-bit lanes
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gLane
            assign errLane[gi] = iErrorSums[32*gi +: 32];
        end
    endgenerate

    // Sum at 35 bits so eight full-scale lanes cannot wrap, then saturate
    always_comb begin
        sumWide = '0;
        for (int j = 0; j < 8; j++) begin
            sumWide = sumWide + {3'b000, errLane[j]};
        end
        fitness = (sumWide[34:32] != 3'b000) ? 32'hFFFF_FFFF : sumWide[31:0];
    end

    // One capture register per description word; only written during LOAD
    generate
        for (genvar gi = 0; gi < WORDS_PER_CHROM; gi++) begin : gSlot
            logic [31:0] slotWord;

            // Capture the RAM word whose address was issued last cycle
            always_ff @(posedge iClock) begin
                if (iReset) begin
                    slotWord <= '0;
                end else if ((state == LOAD) && (wordCount != '0) &&
                             (captureSlot == WCNT_W'(gi))) begin
                    slotWord <= iChromMemData;
                end
            end

            assign oConcatedChromDescription[32*gi +: 32] = slotWord;
        end
    endgenerate

    // Main sequencer: load, handshake, score, acknowledge, advance
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state                   <= IDLE;
            wordCount               <= '0;
            chromBase               <= '0;
            chromIndex              <= '0;
            oChromMemAddr           <= '0;
            oStartProcessing        <= 1'b0;
            oDoneProcessingFeedback <= 1'b0;
            oFitnessWrite           <= 1'b0;
            oFitnessAddr            <= '0;
            oFitnessData            <= '0;
            oBestIndex              <= '0;
            oBestFitness            <= 32'hFFFF_FFFF;
            oPerfectFound           <= 1'b0;
            oGenerationDone         <= 1'b0;
        end else begin
            // Single-cycle strobes fall back low unless re-asserted below
            oStartProcessing <= 1'b0;
            oFitnessWrite    <= 1'b0;
            oGenerationDone  <= 1'b0;

            case (state)
                IDLE: begin
                    if (iStartGeneration) begin
                        chromIndex    <= '0;
                        chromBase     <= '0;
                        wordCount     <= '0;
                        oChromMemAddr <= '0;
                        oBestFitness  <= 32'hFFFF_FFFF;
                        oBestIndex    <= '0;
                        oPerfectFound <= 1'b0;
                        state         <= LOAD;
                    end
                end

                LOAD: begin
                    // Address word c is on the bus during cycle c; stop
                    // advancing once the final word has been addressed.
                    if (wordCount < LAST_WORD) begin
                        oChromMemAddr <= oChromMemAddr + ADDR_WIDTH'(1);
                    end
                    if (wordCount == LOAD_END) begin
                        state <= WAIT_READY;
                    end else begin
                        wordCount <= wordCount + WCNT_W'(1);
                    end
                end

                WAIT_READY: begin
                    // A processor still sitting in DONE holds a result from
                    // an abandoned run: release it without scoring.
                    if (iDoneProcessing) begin
                        oDoneProcessingFeedback <= 1'b1;
                    end else begin
                        oDoneProcessingFeedback <= 1'b0;
                        if (iReadyToProcess) begin
                            oStartProcessing <= 1'b1;
                            state            <= START;
                        end
                    end
                end

                START: begin
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    // Fitness is registered here so it is presented during SCORE
                    if (iDoneProcessing) begin
                        oFitnessWrite <= 1'b1;
                        oFitnessAddr  <= chromIndex;
                        oFitnessData  <= fitness;
                        // Strict compare keeps the lower index on ties
                        if (fitness < oBestFitness) begin
                            oBestFitness <= fitness;
                            oBestIndex   <= chromIndex;
                        end
                        if (fitness == 32'd0) begin
                            oPerfectFound <= 1'b1;
                        end
                        state <= SCORE;
                    end
                end

                SCORE: begin
                    oDoneProcessingFeedback <= 1'b1;
                    state                   <= ACK;
                end

                ACK: begin
                    if (!iDoneProcessing) begin
                        oDoneProcessingFeedback <= 1'b0;
                        state                   <= NEXT;
                    end
                end

                NEXT: begin
                    if (chromIndex == LAST_INDEX) begin
                        oGenerationDone <= 1'b1;
                        state           <= DONE;
                    end else begin
                        chromIndex    <= chromIndex + 8'd1;
                        wordCount     <= '0;
                        chromBase     <= chromBase + CHROM_STRIDE;
                        oChromMemAddr <= chromBase + CHROM_STRIDE;
                        state         <= LOAD;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chromosome_evaluation_sequencer.sv
// Scoreboard bench for chromosome_evaluation_sequencer: a RAM model, a
// behavioural processor model, directed generations with hand-computed
// fitness values, and a negedge monitor that pops expectations.
module tb_chromosome_evaluation_sequencer;

    localparam int POP = 4;
    localparam int WPC = 31;
    localparam int AW  = 13;
    localparam int DW  = WPC * 32;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } fit_exp_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] fit;
        logic        perfect;
    } gen_exp_t;

    logic          clk = 1'b0;
    logic          tbReset;
    logic          startGen;
    logic          busy;
    logic          genDone;
    logic [AW-1:0] memAddr;
    logic [31:0]   memData;
    logic [DW-1:0] desc;
    logic          startProc;
    logic          procReady;
    logic          procDone = 1'b0;
    logic          feedback;
    logic [255:0]  procSums = '0;
    logic          fitWrite;
    logic [7:0]    fitAddr;
    logic [31:0]   fitData;
    logic [7:0]    bestIdx;
    logic [31:0]   bestFit;
    logic          perfect;

    int errors = 0;
    int checks = 0;
    int genDoneCount = 0;
    int startCount = 0;
    int holdCfg = 0;

    fit_exp_t     expFitQ [$];
    gen_exp_t     expGenQ [$];
    int           descQ   [$];
    logic [255:0] sumsQ   [$];
    int           delayQ  [$];

    always #5 clk = ~clk;

    chromosome_evaluation_sequencer #(
        .POP_SIZE(POP), .WORDS_PER_CHROM(WPC), .ADDR_WIDTH(AW)
    ) dut (
        .iClock(clk),
        .iReset(tbReset),
        .iStartGeneration(startGen),
        .oBusy(busy),
        .oGenerationDone(genDone),
        .oChromMemAddr(memAddr),
        .iChromMemData(memData),
        .oConcatedChromDescription(desc),
        .oStartProcessing(startProc),
        .iReadyToProcess(procReady),
        .iDoneProcessing(procDone),
        .oDoneProcessingFeedback(feedback),
        .iErrorSums(procSums),
        .oFitnessWrite(fitWrite),
        .oFitnessAddr(fitAddr),
        .oFitnessData(fitData),
        .oBestIndex(bestIdx),
        .oBestFitness(bestFit),
        .oPerfectFound(perfect)
    );

    // Chromosome RAM: word w holds A000_0000 + w, one-cycle read latency
    logic [31:0] ram [POP*WPC];
    initial begin
        for (int i = 0; i < POP*WPC; i++) ram[i] = 32'hA000_0000 + i;
    end
    always @(posedge clk) begin
        if (int'(memAddr) < POP*WPC) memData <= ram[memAddr];
        else memData <= 32'hDEAD_BEEF;
    end

    // Processor model: IDLE -> RUN(delay) -> DONE, drops done holdCfg
    // cycles after it first sees feedback
    int           pState = 0;
    int           pCnt = 0;
    int           holdCnt = 0;
    logic [255:0] curSums = '0;
    assign procReady = (pState == 0);

    always @(posedge clk) begin
        case (pState)
            0: if (startProc) begin
                startCount <= startCount + 1;
                if (sumsQ.size() > 0) begin
                    curSums <= sumsQ.pop_front();
                    pCnt    <= delayQ.pop_front();
                end else begin
                    curSums <= '0;
                    pCnt    <= 2;
                end
                pState <= 1;
            end
            1: if (pCnt == 0) begin
                pState   <= 2;
                procDone <= 1'b1;
                procSums <= curSums;
                holdCnt  <= holdCfg;
            end else begin
                pCnt <= pCnt - 1;
            end
            default: if (feedback) begin
                if (holdCnt == 0) begin
                    procDone <= 1'b0;
                    pState   <= 0;
                end else begin
                    holdCnt <= holdCnt - 1;
                end
            end
        endcase
    end

    function automatic logic [DW-1:0] expDesc(input int idx);
        logic [DW-1:0] d;
        for (int k = 0; k < WPC; k++) d[32*k +: 32] = 32'hA000_0000 + 32'(idx*WPC + k);
        return d;
    endfunction

    function automatic logic [255:0] lanes(input logic [31:0] a, b, c, d, e, f, g, h);
        return {h, g, f, e, d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic chkDesc(input int idx, input logic [DW-1:0] act);
        logic [DW-1:0] e;
        int bad;
        e = expDesc(idx);
        checks++;
        bad = -1;
        for (int k = WPC-1; k >= 0; k--) if (act[32*k +: 32] !== e[32*k +: 32]) bad = k;
        if (bad >= 0) begin
            errors++;
            $display("FAIL desc idx %0d word %0d: got %0h expected %0h",
                     idx, bad, act[32*bad +: 32], e[32*bad +: 32]);
        end else begin
            $display("ok   desc idx %0d: word0 %0h word%0d %0h", idx, act[31:0], WPC-1, act[DW-1 -: 32]);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event
    logic prevFb = 1'b0;
    logic prevStart = 1'b0;
    always @(negedge clk) begin
        if (fitWrite) begin
            if (expFitQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL fit_unexpected: got addr %0d data %0h expected no write", fitAddr, fitData);
            end else begin
                fit_exp_t fe;
                fe = expFitQ.pop_front();
                chk("fit_addr", 64'(fitAddr), 64'(fe.addr));
                chk("fit_data", 64'(fitData), 64'(fe.data));
            end
        end
        if (startProc) begin
            chk("start_single_cycle", 64'(prevStart), 64'd0);
            if (descQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL start_unexpected: got start pulse expected none");
            end else begin
                chkDesc(descQ.pop_front(), desc);
            end
        end
        if (genDone) begin
            genDoneCount++;
            if (expGenQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL gen_done_unexpected: got pulse expected none");
            end else begin
                gen_exp_t ge;
                ge = expGenQ.pop_front();
                chk("best_index", 64'(bestIdx), 64'(ge.idx));
                chk("best_fitness", 64'(bestFit), 64'(ge.fit));
                chk("perfect_found", 64'(perfect), 64'(ge.perfect));
            end
        end
        if (prevFb && !feedback && !tbReset) chk("fb_released_after_done_low", 64'(procDone), 64'd0);
        prevFb    <= feedback;
        prevStart <= startProc;
    end

    task automatic checkResetOutputs(input string tag);
        $display("-- reset values (%s)", tag);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gen_done", 64'(genDone), 64'd0);
        chk("rst_start", 64'(startProc), 64'd0);
        chk("rst_feedback", 64'(feedback), 64'd0);
        chk("rst_fit_write", 64'(fitWrite), 64'd0);
        chk("rst_perfect", 64'(perfect), 64'd0);
        chk("rst_mem_addr", 64'(memAddr), 64'd0);
        chk("rst_fit_addr", 64'(fitAddr), 64'd0);
        chk("rst_fit_data", 64'(fitData), 64'd0);
        chk("rst_best_idx", 64'(bestIdx), 64'd0);
        chk("rst_best_fit", 64'(bestFit), 64'hFFFF_FFFF);
        chk("rst_desc_zero", 64'(desc == '0), 64'd1);
    endtask

    task automatic pulseStart();
        @(negedge clk); startGen = 1'b1;
        @(negedge clk); startGen = 1'b0;
    endtask

    task automatic pushRun(input logic [255:0] s, input int d);
        sumsQ.push_back(s);
        delayQ.push_back(d);
    endtask

    task automatic waitGenDone(input int budget, input string name);
        int target;
        bit seen;
        target = genDoneCount + 1;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (genDoneCount >= target) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no generation done expected one within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int base;
        bit seen;
        tbReset  = 1'b1;
        startGen = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("power-up");
        tbReset = 1'b0;
        repeat (2) @(negedge clk);

        // Generation A: totals 7,3,3,9; tie at 3 keeps index 1; a start
        // pulse while busy must be ignored
        $display("-- generation A: fitness and best tracking");
        holdCfg = 0;
        pushRun(lanes(1, 1, 1, 1, 1, 1, 1, 0), 5);
        pushRun(lanes(3, 0, 0, 0, 0, 0, 0, 0), 5);
        pushRun(lanes(0, 0, 0, 0, 0, 0, 0, 3), 5);
        pushRun(lanes(2, 2, 2, 1, 1, 1, 0, 0), 5);
        expFitQ.push_back('{8'd0, 32'd7});
        expFitQ.push_back('{8'd1, 32'd3});
        expFitQ.push_back('{8'd2, 32'd3});
        expFitQ.push_back('{8'd3, 32'd9});
        for (int i = 0; i < POP; i++) descQ.push_back(i);
        expGenQ.push_back('{8'd1, 32'd3, 1'b0});
        base = startCount;
        pulseStart();
        repeat (60) @(negedge clk);
        chk("busy_mid_gen", 64'(busy), 64'd1);
        pulseStart();
        waitGenDone(3000, "genA");
        chk("genA_start_pulses", 64'(startCount - base), 64'd4);
        chk("genA_done_pulses", 64'(genDoneCount), 64'd1);
        repeat (3) @(negedge clk);

        // Generation B: saturation, perfect chromosome, long run and
        // delayed done release
        $display("-- generation B: saturation, perfect, slow handshake");
        holdCfg = 3;
        pushRun(lanes(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                      32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000), 5);
        pushRun(lanes(0, 0, 0, 0, 0, 0, 0, 0), 5);
        pushRun(lanes(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0), 500);
        pushRun(lanes(32'h8000_0000, 32'h7FFF_FFFE, 0, 0, 0, 0, 0, 0), 5);
        expFitQ.push_back('{8'd0, 32'hFFFF_FFFF});
        expFitQ.push_back('{8'd1, 32'h0000_0000});
        expFitQ.push_back('{8'd2, 32'hFFFF_FFFF});
        expFitQ.push_back('{8'd3, 32'hFFFF_FFFE});
        for (int i = 0; i < POP; i++) descQ.push_back(i);
        expGenQ.push_back('{8'd1, 32'd0, 1'b1});
        base = startCount;
        pulseStart();
        waitGenDone(5000, "genB");
        chk("genB_start_pulses", 64'(startCount - base), 64'd4);
        repeat (3) @(negedge clk);

        // Generation C: reset while index 2 is in WAIT_DONE
        $display("-- generation C: reset mid-run");
        holdCfg = 1;
        pushRun(lanes(4, 0, 0, 0, 0, 0, 0, 0), 5);
        pushRun(lanes(0, 6, 0, 0, 0, 0, 0, 0), 5);
        pushRun(lanes(0, 0, 99, 0, 0, 0, 0, 0), 200);
        expFitQ.push_back('{8'd0, 32'd4});
        expFitQ.push_back('{8'd1, 32'd6});
        for (int i = 0; i < 3; i++) descQ.push_back(i);
        base = startCount;
        pulseStart();
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (startCount - base >= 3) seen = 1;
        end
        chk("genC_reached_index2", 64'(seen), 64'd1);
        repeat (5) @(negedge clk);
        chk("genC_writes_before_reset", 64'(expFitQ.size()), 64'd0);
        tbReset = 1'b1;
        @(negedge clk);
        checkResetOutputs("mid-run");
        tbReset = 1'b0;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (procDone) seen = 1;
        end
        chk("stale_proc_done", 64'(seen), 64'd1);

        // Generation D: restarts from index 0, releases the stale result
        $display("-- generation D: restart with stale processor result");
        pushRun(lanes(10, 0, 0, 0, 0, 0, 0, 0), 5);
        pushRun(lanes(5, 5, 5, 5, 0, 0, 0, 0), 5);
        pushRun(lanes(1, 0, 0, 0, 0, 0, 0, 1), 5);
        pushRun(lanes(0, 0, 0, 0, 0, 0, 2, 0), 5);
        expFitQ.push_back('{8'd0, 32'd10});
        expFitQ.push_back('{8'd1, 32'd20});
        expFitQ.push_back('{8'd2, 32'd2});
        expFitQ.push_back('{8'd3, 32'd2});
        for (int i = 0; i < POP; i++) descQ.push_back(i);
        expGenQ.push_back('{8'd2, 32'd2, 1'b0});
        base = startCount;
        pulseStart();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (feedback) seen = 1;
        end
        chk("stale_feedback_seen", 64'(seen), 64'd1);
        chk("stale_not_scored", 64'(expFitQ.size()), 64'd4);
        waitGenDone(3000, "genD");
        chk("genD_start_pulses", 64'(startCount - base), 64'd4);
        repeat (3) @(negedge clk);

        chk("fit_queue_drained", 64'(expFitQ.size()), 64'd0);
        chk("desc_queue_drained", 64'(descQ.size()), 64'd0);
        chk("gen_queue_drained", 64'(expGenQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
